// File: rtl/fullchip_pkg.sv
// Shared constants, types and helpers for the multi-core dispatch front-end.
package fullchip_pkg;

    localparam int ID_W   = 3;
    localparam int BW     = 8;
    localparam int PR     = 16;
    localparam int INST_W = 19;

    typedef logic [INST_W-1:0] inst_t;
    typedef logic [PR*BW-1:0]  word_t;

    // Occupancy must represent 0..depth inclusive, hence one extra bit.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Per-core first-word-fall-through FIFO; head is visible whenever valid is high.
module dispatch_fifo
    import fullchip_pkg::*;
#(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [width-1:0]         din,
    input  logic                     pop,
    output logic [width-1:0]         dout,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(depth):0]   occ
);

    localparam int AW = $clog2(depth);
    localparam logic [AW:0] FULL_OCC = (AW+1)'(depth);

    logic [width-1:0] mem_q [depth];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      occ_q, occ_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push = push && (occ_q != FULL_OCC);
        do_pop  = pop && (occ_q != '0);
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        occ_d   = occ_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            occ_q <= occ_d;
        end
    end

    // Storage is intentionally not reset; the head is only meaningful while valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    assign dout  = mem_q[rd_q];
    assign valid = (occ_q != '0);
    assign full  = (occ_q == FULL_OCC);
    assign occ   = occ_q;

endmodule

// File: rtl/fullchip_dispatch.sv
// Host-word dispatcher: unicast/broadcast decode into one FWFT FIFO per core.
module fullchip_dispatch
    import fullchip_pkg::*;
#(
    parameter int n_core = 2,
    parameter int bw     = 8,
    parameter int pr     = 16,
    parameter int inst_w = 19,
    parameter int depth  = 4,
    parameter int id_w   = ID_W
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [pr*bw-1:0]                     in_mem,
    input  logic [inst_w-1:0]                    in_inst,
    input  logic [id_w-1:0]                      in_dest,
    input  logic                                 in_bcast,
    output logic [n_core-1:0]                    out_valid,
    input  logic [n_core-1:0]                    out_ready,
    output logic [n_core*pr*bw-1:0]              out_mem,
    output logic [n_core*inst_w-1:0]             out_inst,
    output logic [n_core*occ_width(depth)-1:0]   occ,
    output logic                                 err_dest
);

    localparam int OW = occ_width(depth);
    localparam int MW = pr * bw;
    localparam int WW = MW + inst_w;

    logic [n_core-1:0] full;
    logic [n_core-1:0] push;
    logic              dest_hit, dest_free, all_free, accept;
    logic              err_q, err_d;

    // in_ready looks only at full flags and the routing fields, never at in_valid.
    always_comb begin
        dest_hit  = 1'b0;
        dest_free = 1'b1;
        all_free  = 1'b1;
        for (int unsigned k = 0; k < n_core; k++) begin
            all_free = all_free & ~full[k];
            if (in_dest == id_w'(k)) begin
                dest_hit  = 1'b1;
                dest_free = ~full[k];
            end
        end
        in_ready = in_bcast ? all_free : (dest_hit ? dest_free : 1'b1);
        accept   = in_valid && in_ready;
        for (int unsigned k = 0; k < n_core; k++) begin
            push[k] = accept && (in_bcast || (in_dest == id_w'(k)));
        end
        err_d = err_q | (accept && !in_bcast && !dest_hit);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err_dest = err_q;

    for (genvar k = 0; k < n_core; k++) begin : g_core
        logic [WW-1:0] dout;

        dispatch_fifo #(
            .width (WW),
            .depth (depth)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[k]),
            .din   ({in_inst, in_mem}),
            .pop   (out_ready[k]),
            .dout  (dout),
            .valid (out_valid[k]),
            .full  (full[k]),
            .occ   (occ[k*OW +: OW])
        );

        assign out_mem[k*MW +: MW]          = dout[MW-1:0];
        assign out_inst[k*inst_w +: inst_w] = dout[WW-1 -: inst_w];
    end

endmodule

// File: tb/tb_fullchip_dispatch.sv
// Bench for fullchip_dispatch: vector table plus per-core scoreboard queues.
module tb_fullchip_dispatch;
    import fullchip_pkg::*;

    localparam int N   = 2;
    localparam int D   = 4;
    localparam int IDW = 3;
    localparam int IW  = 19;
    localparam int MW  = 128;
    localparam int OW  = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid, in_ready, in_bcast, err_dest;
    logic [MW-1:0]    in_mem;
    logic [IW-1:0]    in_inst;
    logic [IDW-1:0]   in_dest;
    logic [N-1:0]     out_valid, out_ready;
    logic [N*MW-1:0]  out_mem;
    logic [N*IW-1:0]  out_inst;
    logic [N*OW-1:0]  occ;

    always #5 clk = ~clk;

    fullchip_dispatch #(
        .n_core (N), .bw (8), .pr (16), .inst_w (IW), .depth (D), .id_w (IDW)
    ) dut (
        .clk (clk), .reset (reset), .in_valid (in_valid), .in_ready (in_ready),
        .in_mem (in_mem), .in_inst (in_inst), .in_dest (in_dest), .in_bcast (in_bcast),
        .out_valid (out_valid), .out_ready (out_ready), .out_mem (out_mem),
        .out_inst (out_inst), .occ (occ), .err_dest (err_dest)
    );

    typedef struct packed { word_t mem; inst_t inst; } wrd_t;
    typedef struct {
        logic v, b; logic [2:0] dest; logic [18:0] inst; logic [7:0] byt; logic [1:0] ordy;
        logic rdy; int occ0, occ1; logic err;
    } vec_t;

    wrd_t  sb0[$], sb1[$];
    inst_t popped0[$];
    vec_t  tbl[19];
    int    nvec = 0, nmis = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int qsz(input int k);
        return (k == 0) ? sb0.size() : sb1.size();
    endfunction

    function automatic logic mready(input logic b, input logic [2:0] dest);
        if (b) return (qsz(0) < D) && (qsz(1) < D);
        if (dest < 3'(N)) return qsz(int'(dest)) < D;
        return 1'b1;
    endfunction

    task automatic peek();
        wrd_t h;
        for (int k = 0; k < N; k++) begin
            chk("valid", 128'(out_valid[k]), 128'(qsz(k) != 0));
            chk("occ", 128'(occ[k*OW +: OW]), 128'(qsz(k)));
            if (qsz(k) != 0) begin
                h = (k == 0) ? sb0[0] : sb1[0];
                chk("head_inst", 128'(out_inst[k*IW +: IW]), 128'(h.inst));
                chk("head_mem", out_mem[k*MW +: MW], h.mem);
            end
        end
    endtask

    task automatic step(input logic v, input logic b, input logic [2:0] dest,
                        input logic [18:0] inst, input logic [7:0] byt,
                        input logic [1:0] ordy, output logic rdy_seen);
        wrd_t w;
        logic acc;
        in_valid = v; in_bcast = b; in_dest = dest; in_inst = inst;
        in_mem = {16{byt}}; out_ready = ordy;
        #1;
        rdy_seen = in_ready;
        acc = v && mready(b, dest);
        w.mem = {16{byt}}; w.inst = inst;
        if (ordy[0] && sb0.size() > 0) begin
            popped0.push_back(out_inst[IW-1:0]);
            w = sb0.pop_front();
        end
        if (ordy[1] && sb1.size() > 0) w = sb1.pop_front();
        w.mem = {16{byt}}; w.inst = inst;
        if (acc) begin
            if (b || dest == 3'd0) sb0.push_back(w);
            if (b || dest == 3'd1) sb1.push_back(w);
        end
        @(posedge clk);
        #1;
        peek();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic r;
        tbl[0]  = '{1'b1,1'b0,3'd1,19'h13,8'hA5,2'b00,1'b1,0,1,1'b0};
        tbl[1]  = '{1'b1,1'b0,3'd1,19'h14,8'hB6,2'b00,1'b1,0,2,1'b0};
        tbl[2]  = '{1'b1,1'b0,3'd1,19'h15,8'hC7,2'b00,1'b1,0,3,1'b0};
        tbl[3]  = '{1'b1,1'b0,3'd1,19'h16,8'hD8,2'b00,1'b1,0,4,1'b0};
        tbl[4]  = '{1'b0,1'b0,3'd1,19'h00,8'h00,2'b00,1'b0,0,4,1'b0};
        tbl[5]  = '{1'b0,1'b0,3'd0,19'h00,8'h00,2'b00,1'b1,0,4,1'b0};
        tbl[6]  = '{1'b1,1'b0,3'd0,19'h20,8'h01,2'b00,1'b1,1,4,1'b0};
        tbl[7]  = '{1'b1,1'b0,3'd0,19'h21,8'h02,2'b00,1'b1,2,4,1'b0};
        tbl[8]  = '{1'b1,1'b0,3'd0,19'h22,8'h03,2'b00,1'b1,3,4,1'b0};
        tbl[9]  = '{1'b1,1'b0,3'd0,19'h23,8'h04,2'b00,1'b1,4,4,1'b0};
        tbl[10] = '{1'b0,1'b1,3'd0,19'h00,8'h00,2'b10,1'b0,4,3,1'b0};
        tbl[11] = '{1'b0,1'b1,3'd0,19'h00,8'h00,2'b10,1'b0,4,2,1'b0};
        tbl[12] = '{1'b0,1'b1,3'd0,19'h00,8'h00,2'b10,1'b0,4,1,1'b0};
        tbl[13] = '{1'b0,1'b1,3'd0,19'h00,8'h00,2'b10,1'b0,4,0,1'b0};
        tbl[14] = '{1'b1,1'b1,3'd0,19'h30,8'h11,2'b00,1'b0,4,0,1'b0};
        tbl[15] = '{1'b1,1'b1,3'd0,19'h30,8'h11,2'b01,1'b0,3,0,1'b0};
        tbl[16] = '{1'b1,1'b1,3'd0,19'h30,8'h11,2'b00,1'b1,4,1,1'b0};
        tbl[17] = '{1'b1,1'b0,3'd5,19'h40,8'h22,2'b00,1'b1,4,1,1'b1};
        tbl[18] = '{1'b0,1'b0,3'd0,19'h00,8'h00,2'b11,1'b0,3,0,1'b1};

        reset = 1'b0; in_valid = 1'b0; in_bcast = 1'b0; in_dest = '0;
        in_inst = '0; in_mem = '0; out_ready = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_occ", 128'(occ), 128'(0));
        chk("rst_err", 128'(err_dest), 128'(0));
        chk("rst_ready", 128'(in_ready), 128'(1));
        @(posedge clk); #1;

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].v, tbl[i].b, tbl[i].dest, tbl[i].inst, tbl[i].byt, tbl[i].ordy, r);
            chk("vec_ready", 128'(r), 128'(tbl[i].rdy));
            chk("vec_occ0", 128'(occ[OW-1:0]), 128'(tbl[i].occ0));
            chk("vec_occ1", 128'(occ[2*OW-1:OW]), 128'(tbl[i].occ1));
            chk("vec_err", 128'(err_dest), 128'(tbl[i].err));
        end

        // Drain, then stream ten words through core 0 with out_ready held high.
        for (int i = 0; i < 20 && (sb0.size() + sb1.size()) > 0; i++)
            step(1'b0, 1'b0, 3'd0, '0, '0, 2'b11, r);
        chk("drained", 128'(occ), 128'(0));
        popped0.delete();
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b0, 3'd0, 19'(i), 8'(i), 2'b01, r);
            chk("b2b_ready", 128'(r), 128'(1));
            chk("b2b_occ0", 128'(occ[OW-1:0]), 128'(1));
        end
        step(1'b0, 1'b0, 3'd0, '0, '0, 2'b01, r);
        chk("b2b_count", 128'(popped0.size()), 128'(10));
        for (int j = 0; j < popped0.size(); j++)
            chk("b2b_order", 128'(popped0[j]), 128'(j + 1));
        chk("err_sticky", 128'(err_dest), 128'(1));

        // Build occ={2,3}, then assert reset between clock edges.
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 3'd0, 19'h60 + 19'(i), 8'h60, 2'b00, r);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'd1, 19'h70 + 19'(i), 8'h70, 2'b00, r);
        chk("pre_rst_occ", 128'(occ), 128'({3'd3, 3'd2}));
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_valid", 128'(out_valid), 128'(0));
        chk("async_occ", 128'(occ), 128'(0));
        chk("async_err", 128'(err_dest), 128'(0));
        sb0.delete(); sb1.delete();
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        step(1'b1, 1'b0, 3'd1, 19'h55, 8'h5A, 2'b00, r);
        chk("post_rst_valid", 128'(out_valid), 128'(2'b10));
        chk("post_rst_inst", 128'(out_inst[2*IW-1:IW]), 128'(19'h55));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
